dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (comb read, sync write) between the rv_core load/store

---
 rtl/dmem_arbiter.sv | 77 +++++++
 tb/tb_dmem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between core (M0) and debug/loader (M1); DMEM_ARB_RR_EN selects round-robin
module dmem_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic [DW-1:0] m0_rdata_o,
  output logic          m0_rvalid_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic          m1_lock_i,
  output logic          m1_gnt_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          m1_rvalid_o,
  output logic          stall_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {OWN_NONE, OWN_M1_LOCK} state_t;
  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          m1_wins;
  logic          rd0, rd1;
  assign starved = starve_cnt == CW'(STARVE_LIMIT);
`ifdef DMEM_ARB_RR_EN
  logic rr_last;
  assign m1_wins = ~rr_last;
  // remember which master was granted last (1 = M1)
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) rr_last <= 1'b1;
    else if (m0_gnt_o | m1_gnt_o) rr_last <= m1_gnt_o;
`else
  assign m1_wins = starved;
`endif
  // grant: lock gives M1 exclusive ownership; otherwise a lone requester wins, contention uses m1_wins
  always_comb begin
    m1_gnt_o  = ~rst_i & m1_req_i & ((state == OWN_M1_LOCK) | ~m0_req_i | m1_wins);
    m0_gnt_o  = ~rst_i & m0_req_i & (state == OWN_NONE) & ~m1_gnt_o;
    state_nxt = (m1_gnt_o & m1_lock_i) ? OWN_M1_LOCK : OWN_NONE;
  end
  assign rd0         = m0_gnt_o & ~m0_we_i;
  assign rd1         = m1_gnt_o & ~m1_we_i;
  assign stall_o     = ~rst_i & m0_req_i & ~m0_gnt_o;
  assign mem_we_o    = (m0_gnt_o & m0_we_i) | (m1_gnt_o & m1_we_i);
  assign mem_addr_o  = m0_gnt_o ? m0_addr_i : m1_gnt_o ? m1_addr_i : '0;
  assign mem_wdata_o = m0_gnt_o ? m0_wdata_i : m1_gnt_o ? m1_wdata_i : '0;
  // ownership state, starvation counter and per-master registered read data
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state       <= OWN_NONE;
      starve_cnt  <= '0;
      m0_rvalid_o <= 1'b0;
      m1_rvalid_o <= 1'b0;
      m0_rdata_o  <= '0;
      m1_rdata_o  <= '0;
    end else begin
      state       <= state_nxt;
      starve_cnt  <= (~m1_req_i | m1_gnt_o) ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
      m0_rvalid_o <= rd0;
      m1_rvalid_o <= rd1;
      if (rd0) m0_rdata_o <= mem_rdata_i;
      if (rd1) m1_rdata_o <= mem_rdata_i;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  localparam int AW = 8, DW = 32, LIM = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, stall, mem_we;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] dmem [256];
  logic pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [DW-1:0] pre_d = '0;
  int n_cmp = 0, n_bad = 0;
  bit m_lock, m_rr, e_g0, e_g1, e_rv0, e_rv1;
  int m_wait;
  logic [DW-1:0] e_rd0, e_rd1;
  logic [DW-1:0] ref_mem [256];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt), .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid),
    .stall_o(stall), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk)
    if (pre_we) dmem[pre_a] <= pre_d;
    else if (mem_we) dmem[mem_addr] <= mem_wdata;

  task automatic model_reset();
    m_lock = 0; m_wait = 0; m_rr = 1; e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
  endtask

  task automatic drive(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic l1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = l1;
  endtask

  // who should own the memory this cycle, from ownership, waiting time and policy
  task automatic predict();
    if (m_lock) begin
      e_g1 = m1_req; e_g0 = 0;
    end else if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
      e_g1 = !m_rr;
`else
      e_g1 = m_wait >= LIM;
`endif
      e_g0 = !e_g1;
    end else begin
      e_g0 = m0_req; e_g1 = m1_req;
    end
  endtask

  // advance one clock and apply the predicted accesses to the reference memory
  task automatic tick();
    @(posedge clk);
    e_rv0 = e_g0 && !m0_we;
    e_rv1 = e_g1 && !m1_we;
    if (e_rv0) e_rd0 = ref_mem[m0_addr];
    if (e_rv1) e_rd1 = ref_mem[m1_addr];
    if (e_g0 && m0_we) ref_mem[m0_addr] = m0_wdata;
    if (e_g1 && m1_we) ref_mem[m1_addr] = m1_wdata;
    m_wait = (m1_req && !e_g1) ? (m_wait < LIM ? m_wait + 1 : LIM) : 0;
    m_lock = e_g1 && m1_lock;
    if (e_g0 || e_g1) m_rr = e_g1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
      #1 predict();
      tick();
    end
  endtask

  task automatic test_reset();
    drive(0, 0, '0, '0, 1, 0, 8'h06, '0, 1);
    #1 predict();
    tick();
    drive(1, 0, 8'h05, '0, 1, 0, 8'h07, '0, 1);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, stall} !== 3'b000) begin
      n_bad++; $display("FAIL reset_gnt: got %b want 000", {m0_gnt, m1_gnt, stall});
    end
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== '0) begin
      n_bad++; $display("FAIL reset_mem: got %h want 0", {mem_we, mem_addr, mem_wdata});
    end
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0) begin
      n_bad++; $display("FAIL reset_rd: got %h want 0", {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 predict();
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      n_bad++; $display("FAIL reset_state: got %b want 10", {m0_gnt, m1_gnt});
    end
    tick();
    idle(1);
  endtask

  task automatic test_read();
    drive(1, 0, 8'h10, '0, 0, 0, '0, '0, 0);
    #1 predict();
    n_cmp++;
    if ({m0_gnt, stall, mem_we, mem_addr} !== {3'b100, 8'h10}) begin
      n_bad++; $display("FAIL read_gnt: got %h want %h", {m0_gnt, stall, mem_we, mem_addr}, {3'b100, 8'h10});
    end
    tick();
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    #1 predict();
    n_cmp++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL read_data: got %b/%h want 1/deadbeef", m0_rvalid, m0_rdata);
    end
    tick();
    #1 predict();
    n_cmp++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL read_hold: got %b/%h want 0/deadbeef", m0_rvalid, m0_rdata);
    end
    tick();
  endtask

`ifndef DMEM_ARB_RR_EN
  task automatic test_starve();
    for (int k = 0; k < 12; k++) begin
      drive(1, 0, AW'(8'h40 + k), '0, 1, 0, 8'h80, '0, 0);
      #1 predict();
      n_cmp++;
      if ({m0_gnt, m1_gnt, stall} !== {k != 8, k == 8, k == 8}) begin
        n_bad++; $display("FAIL starve_c%0d: got %b want %b", k, {m0_gnt, m1_gnt, stall}, {k != 8, k == 8, k == 8});
      end
      if (k == 9) begin
        n_cmp++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== ref_mem[8'h80]) begin
          n_bad++; $display("FAIL starve_rd: got %b/%h want 1/%h", m1_rvalid, m1_rdata, ref_mem[8'h80]);
        end
      end
      tick();
    end
    idle(1);
  endtask

  task automatic test_same_addr();
    drive(1, 1, 8'h30, 32'h1111, 1, 1, 8'h30, 32'h2222, 0);
    #1 predict();
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b10 || mem_wdata !== 32'h1111) begin
      n_bad++; $display("FAIL same_c0: got %b/%h want 10/1111", {m0_gnt, m1_gnt}, mem_wdata);
    end
    tick();
    drive(0, 0, '0, '0, 1, 1, 8'h30, 32'h2222, 0);
    #1 predict();
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b01 || mem_wdata !== 32'h2222) begin
      n_bad++; $display("FAIL same_c1: got %b/%h want 01/2222", {m0_gnt, m1_gnt}, mem_wdata);
    end
    tick();
    idle(1);
    n_cmp++;
    if (dmem[8'h30] !== 32'h2222) begin
      n_bad++; $display("FAIL same_mem: got %h want 2222", dmem[8'h30]);
    end
  endtask
`else
  task automatic test_rr();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, AW'(8'h50 + k), '0, 1, 0, AW'(8'h60 + k), '0, 0);
      #1 predict();
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== {k % 2 == 0, k % 2 == 1}) begin
        n_bad++; $display("FAIL rr_c%0d: got %b want %b", k, {m0_gnt, m1_gnt}, {k % 2 == 0, k % 2 == 1});
      end
      tick();
    end
    idle(1);
  endtask
`endif

  task automatic test_lock_burst();
    logic [DW-1:0] d [4];
    for (int k = 0; k < 4; k++) d[k] = $urandom;
    for (int k = 0; k < 5; k++) begin
      drive(k >= 1, 0, 8'h41, '0, k < 4, 1, AW'(8'h20 + k), k < 4 ? d[k & 3] : '0, k < 3);
      #1 predict();
      n_cmp++;
      if (k < 4) begin
        if ({m1_gnt, m0_gnt, stall, mem_we, mem_addr, mem_wdata} !== {2'b10, k >= 1, 1'b1, AW'(8'h20 + k), d[k & 3]}) begin
          n_bad++; $display("FAIL lock_c%0d: got %h want %h", k, {m1_gnt, m0_gnt, stall, mem_we, mem_addr, mem_wdata},
                            {2'b10, k >= 1, 1'b1, AW'(8'h20 + k), d[k & 3]});
        end
      end else if ({m0_gnt, m1_gnt, stall} !== 3'b100) begin
        n_bad++; $display("FAIL lock_release: got %b want 100", {m0_gnt, m1_gnt, stall});
      end
      tick();
    end
    idle(1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (dmem[8'h20 + k] !== d[k]) begin
        n_bad++; $display("FAIL lock_mem%0d: got %h want %h", k, dmem[8'h20 + k], d[k]);
      end
    end
  endtask

  task automatic test_random();
    bit p0v = 0, p0w = 0, p1v = 0, p1w = 0, p1l = 0;
    logic [AW-1:0] p0a = '0, p1a = '0;
    logic [DW-1:0] p0d = '0, p1d = '0;
    for (int c = 0; c < 400; c++) begin
      if (!p0v && $urandom_range(2) == 0) begin
        p0v = 1; p0w = 1'($urandom_range(1)); p0a = AW'($urandom_range(15)); p0d = $urandom;
      end
      if (!p1v && $urandom_range(2) == 0) begin
        p1v = 1; p1w = 1'($urandom_range(1)); p1a = AW'($urandom_range(15)); p1d = $urandom;
        p1l = $urandom_range(2) == 0;
      end
      drive(p0v, p0w, p0a, p0d, p1v, p1w, p1a, p1d, p1v && p1l);
      #1 predict();
      n_cmp++;
      if ({m0_gnt, m1_gnt, stall} !== {e_g0, e_g1, p0v && !e_g0}) begin
        n_bad++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, {m0_gnt, m1_gnt, stall}, {e_g0, e_g1, p0v && !e_g0});
      end
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {(e_g0 && p0w) || (e_g1 && p1w), e_g0 ? p0a : e_g1 ? p1a : AW'(0),
                                             e_g0 ? p0d : e_g1 ? p1d : DW'(0)}) begin
        n_bad++; $display("FAIL rnd_mem@%0d: got %b/%h/%h", c, mem_we, mem_addr, mem_wdata);
      end
      n_cmp++;
      if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== {e_rv0, e_rv1, e_rd0, e_rd1}) begin
        n_bad++; $display("FAIL rnd_rd@%0d: got %h want %h", c, {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata},
                          {e_rv0, e_rv1, e_rd0, e_rd1});
      end
      tick();
      if (e_g0) p0v = 0;
      if (e_g1) p1v = 0;
    end
    idle(1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_a = AW'(i); pre_d = (i == 16) ? 32'hDEADBEEF : $urandom; ref_mem[i] = pre_d;
    end
    @(negedge clk);
    pre_we = 1'b0;
    rst = 1'b0;
    model_reset();
    test_reset();
    test_read();
`ifndef DMEM_ARB_RR_EN
    test_starve();
`else
    test_rr();
`endif
    test_lock_burst();
`ifndef DMEM_ARB_RR_EN
    test_same_addr();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
